// File: rtl/alu_div_seq.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional early-out for zero divisor or small dividend: define ALU_DIV_EARLY_OUT_EN.
module alu_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] dvd;
  logic [CW-1:0]    count;
  logic             neg_q;
  logic             neg_r;
  logic             dbz;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;
  logic             zero_b;

  // operand magnitudes, trial subtraction and final sign correction
  always_comb begin
    mag_a  = (i_signed && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
    mag_b  = (i_signed && i_divisor[WIDTH-1]) ? -i_divisor : i_divisor;
    zero_b = (i_divisor == '0);
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    fix_q  = neg_q ? -quo : quo;
    fix_r  = neg_r ? -rem : rem;
  end

  // control FSM with registered result outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      quo           <= '0;
      rem           <= '0;
      dvs           <= '0;
      dvd           <= '0;
      count         <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      dbz           <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            dvs    <= mag_b;
            dvd    <= i_dividend;
            neg_q  <= i_signed & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
            neg_r  <= i_signed & i_dividend[WIDTH-1];
            dbz    <= zero_b;
            count  <= CW'(WIDTH);
            o_busy <= 1'b1;
`ifdef ALU_DIV_EARLY_OUT_EN
            if (zero_b || (mag_a < mag_b)) begin
              quo   <= '0;
              rem   <= mag_a;
              state <= FIX;
            end else begin
              quo   <= mag_a;
              rem   <= '0;
              state <= CALC;
            end
`else
            quo   <= mag_a;
            rem   <= '0;
            state <= CALC;
`endif
          end
        end
        CALC: begin
          if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          count <= count - 1'b1;
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (dbz) begin
            o_quotient  <= '1;
            o_remainder <= dvd;
          end else begin
            o_quotient  <= fix_q;
            o_remainder <= fix_r;
          end
          o_div_by_zero <= dbz;
          o_done        <= 1'b1;
          o_busy        <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Scoreboard bench for alu_div_seq: directed vectors, decoupled monitor.
// Latency checks assume the default build (no early-out).
module tb_alu_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sgn;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  alu_div_seq #(.WIDTH(W)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_signed      (sgn),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // monitor: pop expected result whenever the DUT pulses done
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got q=%h r=%h expected none",
                 quotient, remainder);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_q"}, quotient, e.q);
        chk({e.name, "_r"}, remainder, e.r);
        chk({e.name, "_dbz"}, W'(dbz), W'(e.z));
        chk({e.name, "_busy_in_done"}, W'(busy), '0);
      end
    end
  end

  // issue one op; optionally inject an ignored start at edge 5
  task automatic do_op(input string nm, input logic s,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic ez, input bit glitch);
    exp_t e;
    int   n;
    e.q = eq;
    e.r = er;
    e.z = ez;
    e.name = nm;
    sb.push_back(e);
    sgn      = s;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, "_busy"}, W'(busy), W'(1));
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (glitch && n == 5) begin
        start    = 1'b1;
        sgn      = 1'b0;
        dividend = 32'd1000;
        divisor  = 32'd3;
      end
      if (glitch && n == 6) start = 1'b0;
      if (done) break;
    end
    chk({nm, "_latency"}, W'(n), W'(33));
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    sgn      = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    chk("reset_q", quotient, '0);
    chk("reset_r", remainder, '0);
    chk("reset_dbz", W'(dbz), '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    do_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
          32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    do_op("s_dbz", 1'b1, 32'h1234, 32'd0,
          32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0);
    do_op("u_dbz", 1'b0, 32'h1234, 32'd0,
          32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0);
    do_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h8000_0000, 32'd0, 1'b0, 1'b0);
    do_op("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
          32'd0, 32'h8000_0000, 1'b0, 1'b0);
    do_op("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
          32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1,
          32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    do_op("u5_9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b0);
    do_op("u_glitch", 1'b0, 32'd200, 32'd9, 32'd22, 32'd2, 1'b0, 1'b1);

    // let the last done cycle pass, then check results are held
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("hold_q", quotient, 32'd22);
    chk("hold_r", remainder, 32'd2);

    // reset at edge 10 of a new op aborts it
    sgn      = 1'b0;
    dividend = 32'd77;
    divisor  = 32'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("abort_busy", W'(busy), '0);
    chk("abort_q", quotient, '0);
    chk("abort_r", remainder, '0);
    chk("abort_dbz", W'(dbz), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_no_result_q", quotient, '0);

    do_op("post_rst", 1'b1, 32'hFFFF_FF9C, 32'd7,
          32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", W'(sb.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
